pcie_cq_mem_completer: RTL

- Completer-side counterpart of the DMA requester path.
- Accepts CPU-initiated memory TLPs from the PCIe core completer-request (CQ) AXI-Stream and turns them into accesses on the 64-bit register memory interface that feeds the DMA engine tables.
- For reads, returns a single-beat completion on the completer-completion (CC) AXI-Stream.
- Handles one request at a time; single-beat 1-DW and 2-DW accesses only.

---
 rtl/pcie_cq_mem_completer_if.sv | 56 +++++
 rtl/pcie_cq_mem_completer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_cq_mem_completer_if.sv
// ---------------------------------------------------------------------------
// pcie_cq_mem_completer_if
//   Bundle of the three buses that surround the completer:
//     - CQ  : completer-request AXI-Stream from the PCIe core (into completer)
//     - CC  : completer-completion AXI-Stream back to the core
//     - MEM : 64-bit register memory interface toward the DMA engine tables
//   Modports:
//     master : completer side (consumes CQ, produces CC, drives MEM requests)
//     slave  : environment side (PCIe core + register memory)
// ---------------------------------------------------------------------------
interface pcie_cq_mem_completer_if #(
  parameter int C_BUS_DATA_WIDTH = 256,
  parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 32,
  parameter int C_ADDR_WIDTH     = 24,
  parameter int C_DATA_WIDTH     = 64
);
  // CQ stream
  logic [C_BUS_DATA_WIDTH-1:0] S_AXIS_CQ_TDATA;
  logic [84:0]                 S_AXIS_CQ_TUSER;
  logic                        S_AXIS_CQ_TLAST;
  logic [C_BUS_KEEP_WIDTH-1:0] S_AXIS_CQ_TKEEP;
  logic                        S_AXIS_CQ_TVALID;
  logic [21:0]                 S_AXIS_CQ_TREADY;
  // CC stream
  logic [C_BUS_DATA_WIDTH-1:0] M_AXIS_CC_TDATA;
  logic [32:0]                 M_AXIS_CC_TUSER;
  logic                        M_AXIS_CC_TLAST;
  logic [C_BUS_KEEP_WIDTH-1:0] M_AXIS_CC_TKEEP;
  logic                        M_AXIS_CC_TVALID;
  logic [3:0]                  M_AXIS_CC_TREADY;
  // Register memory interface
  logic                        M_MEM_IFACE_EN;
  logic [C_ADDR_WIDTH-1:0]     M_MEM_IFACE_ADDR;
  logic [C_DATA_WIDTH-1:0]     M_MEM_IFACE_DOUT;
  logic [C_DATA_WIDTH-1:0]     M_MEM_IFACE_DIN;
  logic [C_DATA_WIDTH/8-1:0]   M_MEM_IFACE_WE;
  logic                        M_MEM_IFACE_ACK;

  modport master (
    input  S_AXIS_CQ_TDATA, S_AXIS_CQ_TUSER, S_AXIS_CQ_TLAST, S_AXIS_CQ_TKEEP, S_AXIS_CQ_TVALID,
    output S_AXIS_CQ_TREADY,
    output M_AXIS_CC_TDATA, M_AXIS_CC_TUSER, M_AXIS_CC_TLAST, M_AXIS_CC_TKEEP, M_AXIS_CC_TVALID,
    input  M_AXIS_CC_TREADY,
    output M_MEM_IFACE_EN, M_MEM_IFACE_ADDR, M_MEM_IFACE_DOUT, M_MEM_IFACE_WE,
    input  M_MEM_IFACE_DIN, M_MEM_IFACE_ACK
  );

  modport slave (
    output S_AXIS_CQ_TDATA, S_AXIS_CQ_TUSER, S_AXIS_CQ_TLAST, S_AXIS_CQ_TKEEP, S_AXIS_CQ_TVALID,
    input  S_AXIS_CQ_TREADY,
    input  M_AXIS_CC_TDATA, M_AXIS_CC_TUSER, M_AXIS_CC_TLAST, M_AXIS_CC_TKEEP, M_AXIS_CC_TVALID,
    output M_AXIS_CC_TREADY,
    input  M_MEM_IFACE_EN, M_MEM_IFACE_ADDR, M_MEM_IFACE_DOUT, M_MEM_IFACE_WE,
    output M_MEM_IFACE_DIN, M_MEM_IFACE_ACK
  );
endinterface

// File: rtl/pcie_cq_mem_completer.sv
// ---------------------------------------------------------------------------
// pcie_cq_mem_completer
//   Completer for CPU-initiated single-beat 1-DW / 2-DW memory TLPs. A CQ
//   request is decoded on its first beat, turned into one access on the
//   64-bit register memory interface, and for reads answered with a
//   single-beat completion on CC. Unsupported reads get a UR completion,
//   unsupported writes are silently dropped. One request in flight at a time.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : pcie_cq_mem_completer_if.master (CQ in, CC out, MEM out)
// Optional build macro:
//   PCIE_CQ_ACK_TIMEOUT_EN : abandon a memory access after C_ACK_TIMEOUT
//                            cycles without ACK (reads complete with CA).
// ---------------------------------------------------------------------------
module pcie_cq_mem_completer #(
  parameter int C_BUS_DATA_WIDTH = 256,
  parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 32,
  parameter int C_ADDR_WIDTH     = 24,
  parameter int C_DATA_WIDTH     = 64,
  parameter int C_BAR_ID         = 0,
  parameter int C_ACK_TIMEOUT    = 1024
) (
  input logic CLK,
  input logic RST_N,
  pcie_cq_mem_completer_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, MEM = 2'd2, CPL = 2'd3} state_t;
  typedef enum logic [1:0] {ACT_NONE = 2'd0, ACT_MEM = 2'd1, ACT_UR = 2'd2} act_t;

  localparam logic [2:0] ST_SC = 3'b000;
  localparam logic [2:0] ST_UR = 3'b001;
  localparam logic [2:0] ST_CA = 3'b100;

  state_t      state_reg, state_next;
  act_t        pend_reg, pend_next, act_dec;
  logic [2:0]  status_reg, status_next;
  logic        run_reg;
  logic        tready_int, cq_hs;

  // Request fields captured on the first beat
  logic [C_ADDR_WIDTH-1:0] addr_reg;
  logic                    read_reg, dw2_reg;
  logic [10:0]             dw_cnt_reg;
  logic [3:0]              first_be_reg, last_be_reg;
  logic [15:0]             req_id_reg;
  logic [7:0]              tag_reg;
  logic [2:0]              tc_reg, attr_reg;
  logic [7:0]              we_reg;
  logic [63:0]             wdata_reg, rdata_reg;

  // First-beat decode
  logic [3:0]  req_type;
  logic [10:0] req_dw;
  logic [2:0]  req_bar;
  logic [3:0]  cq_first_be, cq_last_be;
  logic [31:0] cq_dw0;
  logic        is_read, is_write, supported;

  assign req_type    = bus.S_AXIS_CQ_TDATA[78:75];
  assign req_dw      = bus.S_AXIS_CQ_TDATA[74:64];
  assign req_bar     = bus.S_AXIS_CQ_TDATA[114:112];
  assign cq_first_be = bus.S_AXIS_CQ_TUSER[3:0];
  assign cq_last_be  = bus.S_AXIS_CQ_TUSER[7:4];
  assign cq_dw0      = bus.S_AXIS_CQ_TDATA[159:128];
  assign is_read     = (req_type == 4'b0000);
  assign is_write    = (req_type == 4'b0001);
  // 2-DW accesses must not straddle a 64-bit word (byte address bit 2 clear)
  assign supported   = (is_read || is_write) && (req_bar == 3'(C_BAR_ID)) &&
                       ((req_dw == 11'd1) || ((req_dw == 11'd2) && !bus.S_AXIS_CQ_TDATA[2]));

  always_comb begin
    act_dec = ACT_NONE;
    if (supported)    act_dec = ACT_MEM;
    else if (is_read) act_dec = ACT_UR;
  end

  // run_reg keeps TREADY low while in reset and for the first cycle after it
  assign tready_int = run_reg && ((state_reg == IDLE) || (state_reg == DRAIN));
  assign cq_hs      = tready_int && bus.S_AXIS_CQ_TVALID;

  function automatic state_t act_to_state(input act_t a);
    case (a)
      ACT_MEM: return MEM;
      ACT_UR:  return CPL;
      default: return IDLE;
    endcase
  endfunction

  // Zero enables below the lowest set bit
  function automatic logic [1:0] low_zeros(input logic [3:0] be);
    casez (be)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Zero enables above the highest set bit
  function automatic logic [1:0] high_zeros(input logic [3:0] be);
    casez (be)
      4'b1???: return 2'd0;
      4'b01??: return 2'd1;
      4'b001?: return 2'd2;
      4'b0001: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

`ifdef PCIE_CQ_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(C_ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                 cnt_reg <= '0;
    else if (state_reg != MEM)  cnt_reg <= '0;
    else                        cnt_reg <= cnt_reg + 1'b1;
  end

  assign timeout_hit = (cnt_reg == CNT_W'(C_ACK_TIMEOUT - 1));
`else
  localparam int unused_timeout = C_ACK_TIMEOUT;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      pend_reg   <= ACT_NONE;
      status_reg <= ST_SC;
      run_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pend_reg   <= pend_next;
      status_reg <= status_next;
      run_reg    <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    pend_next   = pend_reg;
    status_next = status_reg;
    case (state_reg)
      IDLE: begin
        if (cq_hs) begin
          status_next = supported ? ST_SC : ST_UR;
          // Multi-beat TLPs are swallowed first; the decoded action waits
          if (!bus.S_AXIS_CQ_TLAST) begin
            state_next = DRAIN;
            pend_next  = act_dec;
          end else begin
            state_next = act_to_state(act_dec);
          end
        end
      end
      DRAIN: begin
        if (cq_hs && bus.S_AXIS_CQ_TLAST) state_next = act_to_state(pend_reg);
      end
      MEM: begin
        if (bus.M_MEM_IFACE_ACK) begin
          state_next = read_reg ? CPL : IDLE;
        end
`ifdef PCIE_CQ_ACK_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next  = read_reg ? CPL : IDLE;
          status_next = ST_CA;
        end
`endif
      end
      CPL: begin
        if (bus.M_AXIS_CC_TREADY[0]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture and read data latch
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_reg     <= '0;
      read_reg     <= 1'b0;
      dw2_reg      <= 1'b0;
      dw_cnt_reg   <= '0;
      first_be_reg <= '0;
      last_be_reg  <= '0;
      req_id_reg   <= '0;
      tag_reg      <= '0;
      tc_reg       <= '0;
      attr_reg     <= '0;
      we_reg       <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      if ((state_reg == IDLE) && cq_hs) begin
        addr_reg     <= {bus.S_AXIS_CQ_TDATA[C_ADDR_WIDTH-1:2], 2'b00};
        read_reg     <= is_read;
        dw2_reg      <= (req_dw == 11'd2);
        dw_cnt_reg   <= req_dw;
        first_be_reg <= cq_first_be;
        last_be_reg  <= cq_last_be;
        req_id_reg   <= bus.S_AXIS_CQ_TDATA[95:80];
        tag_reg      <= bus.S_AXIS_CQ_TDATA[103:96];
        tc_reg       <= bus.S_AXIS_CQ_TDATA[123:121];
        attr_reg     <= bus.S_AXIS_CQ_TDATA[126:124];
        if (req_dw == 11'd2) begin
          we_reg    <= {cq_last_be, cq_first_be};
          wdata_reg <= bus.S_AXIS_CQ_TDATA[191:128];
        end else if (bus.S_AXIS_CQ_TDATA[2]) begin
          we_reg    <= {cq_first_be, 4'h0};
          wdata_reg <= {cq_dw0, 32'h0};
        end else begin
          we_reg    <= {4'h0, cq_first_be};
          wdata_reg <= {32'h0, cq_dw0};
        end
      end
      if ((state_reg == MEM) && bus.M_MEM_IFACE_ACK) rdata_reg <= bus.M_MEM_IFACE_DIN;
    end
  end

  // Memory interface: held stable for the whole MEM state
  assign bus.M_MEM_IFACE_EN   = (state_reg == MEM);
  assign bus.M_MEM_IFACE_ADDR = (state_reg == MEM) ? {addr_reg[C_ADDR_WIDTH-1:3], 3'b000} : '0;
  assign bus.M_MEM_IFACE_WE   = ((state_reg == MEM) && !read_reg) ? we_reg : '0;
  assign bus.M_MEM_IFACE_DOUT = (state_reg == MEM) ? wdata_reg : '0;

  assign bus.S_AXIS_CQ_TREADY = {22{tready_int}};

  // Completion build
  logic [1:0]  lz_first, hz_first, hz_last;
  logic [12:0] byte_count;
  logic [C_BUS_DATA_WIDTH-1:0] cc_data;
  logic [C_BUS_KEEP_WIDTH-1:0] cc_keep;

  assign lz_first = low_zeros(first_be_reg);
  assign hz_first = high_zeros(first_be_reg);
  assign hz_last  = high_zeros(last_be_reg);

  always_comb begin
    if (dw2_reg)                    byte_count = 13'd8 - 13'(lz_first) - 13'(hz_last);
    else if (first_be_reg == 4'h0)  byte_count = 13'd1;
    else                            byte_count = 13'd4 - 13'(lz_first) - 13'(hz_first);
  end

  always_comb begin
    cc_data = '0;
    cc_keep = '0;
    if (state_reg == CPL) begin
      cc_data[6:0]   = {addr_reg[6:2], lz_first};
      cc_data[28:16] = (status_reg == ST_SC) ? byte_count : 13'd0;
      cc_data[42:32] = (status_reg == ST_CA) ? 11'd0 : dw_cnt_reg;
      cc_data[45:43] = status_reg;
      cc_data[63:48] = req_id_reg;
      cc_data[71:64] = tag_reg;
      cc_data[91:89] = tc_reg;
      cc_data[94:92] = attr_reg;
      if (status_reg != ST_SC) begin
        cc_keep = C_BUS_KEEP_WIDTH'(8'h07);
      end else if (dw2_reg) begin
        cc_data[159:96] = rdata_reg;
        cc_keep         = C_BUS_KEEP_WIDTH'(8'h1F);
      end else begin
        cc_data[127:96] = addr_reg[2] ? rdata_reg[63:32] : rdata_reg[31:0];
        cc_keep         = C_BUS_KEEP_WIDTH'(8'h0F);
      end
    end
  end

  assign bus.M_AXIS_CC_TDATA  = cc_data;
  assign bus.M_AXIS_CC_TKEEP  = cc_keep;
  assign bus.M_AXIS_CC_TVALID = (state_reg == CPL);
  assign bus.M_AXIS_CC_TLAST  = (state_reg == CPL);
  assign bus.M_AXIS_CC_TUSER  = '0;

  // Inputs only partly consumed
  logic unused_inputs;
  assign unused_inputs = ^{bus.S_AXIS_CQ_TDATA, bus.S_AXIS_CQ_TUSER, bus.S_AXIS_CQ_TKEEP,
                           bus.M_AXIS_CC_TREADY};

endmodule
